pan_collector: RTL

Parametrised successor to the fixed 16-digit PAN input stage. It collects a variable-length PAN (MIN_LEN..MAX_LEN BCD digits) and flags malformed input: short, long, or non-decimal digits. It holds each completed record behind a valid/ready handshake so the downstream Luhn/IIN checker can back-pressure the input stream. It sits between the keypad/serial digit source and the validation pipeline.

---
 rtl/pan_collector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pan_collector.sv
// pan_collector: gathers a variable-length BCD PAN from a digit stream,
// flags short/long/non-decimal input, and holds the finished record behind
// a valid/ready handshake so the downstream checker can stall the source.
//
// Handshake: the record is offered while out_valid is high and is consumed
// on any rising edge where out_valid && out_ready. The offer never drops
// before consumption, and the held fields stay constant while it stands.
// in_ready tells the digit source whether start/digit/pan_end are accepted
// this cycle. It is low only while a record waits with out_ready low.
module pan_collector #(
  parameter int MIN_LEN    = 12,
  parameter int MAX_LEN    = 19,
  parameter int IIN_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pan_end,
  input  logic                 digit_valid,
  input  logic [3:0]           digit_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*MAX_LEN-1:0] pan_bcd,
  output logic [4:0]           len_final,
  output logic [31:0]          iin_prefix,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_digit,
  output logic                 card_done,
  output logic                 aborted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] count;
  logic [4:0] len_next;
  logic       clear;
  logic       accept;
  logic       bad_digit;
  logic       overflow;
  logic       finish;
  logic       restart;

  // State register; reset drops any partial card without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus per-cycle datapath controls, with start taking priority.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    bad_digit  = 1'b0;
    overflow   = 1'b0;
    finish     = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (start) begin
          // Restart drops any digit or pan_end that arrives in the same cycle.
          clear   = 1'b1;
          restart = 1'b1;
        end else begin
          if (digit_valid) begin
            if (digit_in > 4'd9)              bad_digit = 1'b1;
            else if (count < 5'(MAX_LEN))     accept    = 1'b1;
            else                              overflow  = 1'b1;
          end
          if (pan_end) begin
            finish     = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            clear      = 1'b1;
            state_next = COLLECT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A digit accepted together with pan_end still counts toward the length.
  assign len_next  = count + {4'd0, accept};
  assign in_ready  = (state != HOLD) || out_ready;
  assign out_valid = (state == HOLD);

  // Digit buffer, counters, sticky error flags and one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pan_bcd    <= '0;
      count      <= '0;
      len_final  <= '0;
      iin_prefix <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_digit  <= 1'b0;
      card_done  <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      card_done <= finish;
      aborted   <= restart;
      if (clear) begin
        pan_bcd    <= '0;
        count      <= '0;
        len_final  <= '0;
        iin_prefix <= '0;
        err_short  <= 1'b0;
        err_long   <= 1'b0;
        err_digit  <= 1'b0;
      end else begin
        if (accept) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (count == 5'(i)) pan_bcd[4*i +: 4] <= digit_in;
          end
          for (int i = 0; i < IIN_DIGITS; i++) begin
            if (count == 5'(i)) iin_prefix[4*i +: 4] <= digit_in;
          end
          count <= len_next;
        end
        if (bad_digit) err_digit <= 1'b1;
        if (overflow)  err_long  <= 1'b1;
        if (finish) begin
          len_final <= len_next;
          err_short <= (len_next < 5'(MIN_LEN));
        end
      end
    end
  end

endmodule
